serial_sub4: RTL and testbench
==============================

# serial_sub4

Bit-serial two's-complement subtractor: computes A − B one bit per clock, LSB first, through a single full-adder slice with B inverted and initial carry 1. It is the subtract-direction counterpart of the 4-bit ripple-carry adder in the ALU datapath. It trades WIDTH cycles of latency for one adder cell and uses a start/busy/done handshake toward the ALU sequencer.

## Interface
- WIDTH, 4, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when not busy
- a  input  WIDTH  minuend, captured on accepted start
- b  input  WIDTH  subtrahend, captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse, result registers just updated
- diff  output  WIDTH  A − B mod 2^WIDTH
- borrow  output  1  1 when A < B unsigned (inverse of final carry)
- ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB)

## Operation
- Clock is clk; reset is rst, synchronous and active-high; nothing changes except on clk rising edge.
- States:
  - IDLE: waiting for start.
  - RUN: processing bits.
  - DONE: one cycle, done=1.
- IDLE/DONE, start=1 → RUN:
  - Latch a and b into shift registers.
  - Set carry=1 and bit counter=0.
  - A start in DONE is accepted exactly like one in IDLE.
- RUN, each cycle (bit i = counter):
  - s = a_i ^ ~b_i ^ c; c' = majority(a_i, ~b_i, c).
  - Shift s into the partial-result register from the MSB side.
  - Counter increments.
  - Record the carry into bit WIDTH−1 when i = WIDTH−1.
- RUN, counter = WIDTH−1 → DONE:
  - On that edge load diff, borrow = ~c', and ovf = c_in(MSB) ^ c'.
- DONE → IDLE when start=0; → RUN when start=1.
- start while in RUN: ignored. Operands and result are unaffected.
- diff, borrow and ovf change only on the completion edge. Between completions they hold the last result; they are not cleared by a new start.
- busy = (state == RUN). done = (state == DONE).
- Reset in any state, including mid-RUN:
  - State → IDLE; counter, carry and shift registers → 0.
  - diff, borrow, ovf, busy, done → 0.
  - The partial operation is discarded; no done pulse.

## Timing
- Reset values: busy=0, done=0, diff=0, borrow=0, ovf=0.
- Start accepted at edge E0:
  - busy=1 from E0 through E(WIDTH), i.e. for WIDTH cycles.
  - Results valid and done=1 after edge E(WIDTH), for exactly one cycle.
  - Latency is WIDTH+1 edges from start to the end of done; WIDTH=4 → done in the 5th cycle after the start cycle.
- Back-to-back: start held high continuously gives one result every WIDTH+1 cycles. The next operation's operands are captured on the edge ending the done cycle.
- a and b are don't-care after the accepting edge.
- Counter width is clog2(WIDTH). It must not wrap into another RUN cycle; the exit is decided on counter == WIDTH−1.

## Test plan
- After rst, start=1, a=9, b=3 → 4 busy cycles, then done pulse with diff=6, borrow=0, ovf=1 (−7−3 overflows).
- a=3, b=9 → diff=0xA, borrow=1, ovf=1; busy exactly 4 cycles; done exactly 1 cycle.
- a=5, b=5 → diff=0, borrow=0, ovf=0. Then a=7, b=8 → diff=0xF, borrow=1, ovf=1.
- Pulse start again in cycle 2 of RUN with a=0xF, b=0 → ignored; the first result (a=3, b=9) is delivered unchanged at the original time.
- Assert rst in the 3rd RUN cycle → next cycle busy=0, done=0, diff=0; no done pulse follows.
- Hold start=1 with a=0, b=1 then a=4, b=1 → done pulses 5 cycles apart:
  - diff=0xF, borrow=1, ovf=0
  - then diff=3, borrow=0, ovf=0

Source files
------------

// File: rtl/serial_sub4.sv
// Bit-serial two's-complement subtractor: A - B computed LSB first through one
// full-adder slice (B inverted, carry-in 1), with a start/busy/done handshake.
module serial_sub4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-2:0]   r_part;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;
    logic               r_ovf;

    logic               w_accept;
    logic               w_last;
    logic               w_nb;
    logic               w_sum;
    logic               w_cout;
    logic [WIDTH-1:0]   w_shift;

    // A start is honoured in IDLE and DONE alike; it is ignored while running.
    assign w_accept = (r_state != S_RUN) && start;
    assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH - 1));

    assign w_nb    = ~r_b[0];
    assign w_sum   = r_a[0] ^ w_nb ^ r_carry;
    assign w_cout  = (r_a[0] & w_nb) | (r_a[0] & r_carry) | (w_nb & r_carry);
    assign w_shift = {w_sum, r_part};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_RUN);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_part   <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= 1'b1;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_cout;
            r_cnt   <= r_cnt + CNT_W'(1);
            r_part  <= w_shift[WIDTH-1:1];
            // On the MSB cycle r_carry is the carry into the MSB, w_cout the carry out.
            if (w_last) begin
                r_diff   <= w_shift;
                r_borrow <= ~w_cout;
                r_ovf    <= r_carry ^ w_cout;
            end
        end
    end

    assign diff   = r_diff;
    assign borrow = r_borrow;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_serial_sub4.sv
// Directed bench for serial_sub4: handshake timing, results, ignored start,
// mid-run reset and back-to-back operation.
module tb_serial_sub4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [3:0] diff;
    logic       borrow;
    logic       ovf;

    int checks = 0;
    int passes = 0;

    serial_sub4 #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_result(input string tag, input logic [3:0] ed, input logic eb, input logic eo);
        chk({tag, " done"},   {7'd0, done},   8'd1);
        chk({tag, " busy"},   {7'd0, busy},   8'd0);
        chk({tag, " diff"},   {4'd0, diff},   {4'd0, ed});
        chk({tag, " borrow"}, {7'd0, borrow}, {7'd0, eb});
        chk({tag, " ovf"},    {7'd0, ovf},    {7'd0, eo});
        $display("txn %s: diff=%0h borrow=%0b ovf=%0b", tag, diff, borrow, ovf);
    endtask

    // Start one operation, check 4 busy cycles, the done pulse and the return to idle.
    task automatic run_op(input string tag, input logic [3:0] ia, input logic [3:0] ib,
                          input logic [3:0] ed, input logic eb, input logic eo);
        a = ia; b = ib; start = 1'b1;
        step();
        start = 1'b0; a = 4'h0; b = 4'h0;
        for (int i = 0; i < 4; i++) begin
            chk({tag, " run busy"}, {7'd0, busy}, 8'd1);
            chk({tag, " run done"}, {7'd0, done}, 8'd0);
            step();
        end
        chk_result(tag, ed, eb, eo);
        step();
        chk({tag, " post done"}, {7'd0, done}, 8'd0);
        chk({tag, " post busy"}, {7'd0, busy}, 8'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = 4'h0; b = 4'h0;
        step();
        step();
        rst = 1'b0;
        chk("reset busy",   {7'd0, busy},   8'd0);
        chk("reset done",   {7'd0, done},   8'd0);
        chk("reset diff",   {4'd0, diff},   8'd0);
        chk("reset borrow", {7'd0, borrow}, 8'd0);
        chk("reset ovf",    {7'd0, ovf},    8'd0);

        run_op("9-3", 4'd9, 4'd3, 4'h6, 1'b0, 1'b1);
        run_op("3-9", 4'd3, 4'd9, 4'hA, 1'b1, 1'b1);
        run_op("5-5", 4'd5, 4'd5, 4'h0, 1'b0, 1'b0);
        run_op("7-8", 4'd7, 4'd8, 4'hF, 1'b1, 1'b1);

        // Start pulsed in the second RUN cycle must not disturb the operation.
        a = 4'd3; b = 4'd9; start = 1'b1;
        step();
        start = 1'b0;
        chk("ign cyc1 busy", {7'd0, busy}, 8'd1);
        chk("ign hold diff", {4'd0, diff}, 8'h0F);
        step();
        a = 4'hF; b = 4'h0; start = 1'b1;
        chk("ign cyc2 busy", {7'd0, busy}, 8'd1);
        step();
        start = 1'b0;
        chk("ign cyc3 busy", {7'd0, busy}, 8'd1);
        chk("ign cyc3 done", {7'd0, done}, 8'd0);
        step();
        chk("ign cyc4 busy", {7'd0, busy}, 8'd1);
        step();
        chk_result("ign 3-9", 4'hA, 1'b1, 1'b1);
        step();
        chk("ign post done", {7'd0, done}, 8'd0);

        // Reset in the third RUN cycle discards the operation.
        a = 4'd9; b = 4'd3; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("rstrun cyc3 busy", {7'd0, busy}, 8'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstrun busy",   {7'd0, busy},   8'd0);
        chk("rstrun done",   {7'd0, done},   8'd0);
        chk("rstrun diff",   {4'd0, diff},   8'd0);
        chk("rstrun borrow", {7'd0, borrow}, 8'd0);
        chk("rstrun ovf",    {7'd0, ovf},    8'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rstrun no done", {7'd0, done}, 8'd0);
        end
        $display("txn reset mid-run: no done pulse");

        // Back-to-back with start held high: results 5 cycles apart.
        a = 4'd0; b = 4'd1; start = 1'b1;
        step();
        a = 4'd4; b = 4'd1;
        for (int i = 0; i < 4; i++) begin
            chk("b2b first busy", {7'd0, busy}, 8'd1);
            step();
        end
        chk_result("b2b 0-1", 4'hF, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("b2b gap done", {7'd0, done}, 8'd0);
            chk("b2b gap busy", {7'd0, busy}, 8'd1);
        end
        step();
        chk_result("b2b 4-1", 4'h3, 1'b0, 1'b0);
        start = 1'b0;
        step();
        chk("b2b end done", {7'd0, done}, 8'd0);
        chk("b2b end busy", {7'd0, busy}, 8'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
